// File: rtl/rb_scheduler_pkg.sv
// Shared types and width helpers for the row-buffer scheduler.
// Holds the state encoding and the clog2-derived width rule used by every file.
package rb_scheduler_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int DEF_K       = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } rb_state_e;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rb_pos_counter.sv
// Column / row-slot / image-row position counter for the row buffer.
// Moves only on advance; clear restarts a frame at the origin.
module rb_pos_counter
    import rb_scheduler_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int SLOTS = DEF_K - 1,
    localparam int CW   = cw(IMG_W),
    localparam int SW   = cw(SLOTS),
    localparam int RW   = cw(IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [SW-1:0] slot,
    output logic [RW-1:0] row,
    output logic          row_last,
    output logic          frame_last
);

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            slot <= '0;
            row  <= '0;
        end else if (clear) begin
            col  <= '0;
            slot <= '0;
            row  <= '0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col  <= '0;
                slot <= (slot == SLOT_MAX) ? '0 : slot + SW'(1);
                row  <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign row_last   = (col == COL_MAX);
    assign frame_last = row_last && (row == ROW_MAX);

endmodule

// File: rtl/rb_scheduler.sv
// Row-buffer scheduler: primes K-1 rows into BRAM, then streams K-pixel window columns.
// Handshake: a pixel moves only when advance is high; out_ready gates issue in STREAM only.
module rb_scheduler
    import rb_scheduler_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = DEF_K,
    localparam int CW   = cw(IMG_W),
    localparam int SW   = cw(K - 1),
    localparam int RW   = cw(IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pix_valid,
    input  logic          out_ready,
    output logic          pix_take,
    output logic          wr_en,
    output logic          rd_en,
    output logic [CW-1:0] col,
    output logic [SW-1:0] wr_row,
    output logic [SW-1:0] steer,
    output logic          win_valid,
    output logic          busy,
    output logic          complete,
    output rb_state_e     state_dbg
);

    if (IMG_H < K) begin : g_bad_height
        $error("rb_scheduler: IMG_H must be at least K");
    end
    if (K < 2) begin : g_bad_k
        $error("rb_scheduler: K must be at least 2");
    end

    localparam logic [RW-1:0] PRIME_LAST_ROW = RW'(K - 2);

    rb_state_e     state_q, state_d;
    logic          advance, clear;
    logic          row_last, frame_last;
    logic [RW-1:0] row;

    rb_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .SLOTS (K - 1)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (advance),
        .col        (col),
        .slot       (wr_row),
        .row        (row),
        .row_last   (row_last),
        .frame_last (frame_last)
    );

    assign advance = ((state_q == ST_PRIME)  && pix_valid) ||
                     ((state_q == ST_STREAM) && pix_valid && out_ready);
    assign clear   = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_PRIME;
            ST_PRIME:  if (advance && row_last && (row == PRIME_LAST_ROW)) state_d = ST_STREAM;
            ST_STREAM: if (advance && frame_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_take = advance;
        wr_en    = advance;
        rd_en    = advance && (state_q == ST_STREAM);
        busy     = (state_q == ST_PRIME) || (state_q == ST_STREAM);
        complete = (state_q == ST_DONE);
    end

    // The BRAM read of slot wr_row lands one cycle later, so steer and win_valid lag by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            steer     <= '0;
        end else begin
            win_valid <= advance && (state_q == ST_STREAM);
            steer     <= wr_row;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_rb_scheduler.sv
// Directed + randomized bench for rb_scheduler against a pixel-index reference model.
module tb_rb_scheduler;
    import rb_scheduler_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int K     = 5;
    localparam int CW    = cw(IMG_W);
    localparam int SW    = cw(K - 1);
    localparam int PRIME_PIX = (K - 1) * IMG_W;
    localparam int FRAME_PIX = IMG_H * IMG_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          pix_take, wr_en, rd_en, win_valid, busy, complete;
    logic [CW-1:0] col;
    logic [SW-1:0] wr_row, steer;
    rb_state_e     state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: frame phase plus the index of the next pixel to be taken.
    rb_state_e     m_ph = ST_IDLE;
    int            m_n = 0;
    logic          m_win = 1'b0;
    logic [SW-1:0] m_steer = '0;
    logic [SW-1:0] exp_q[$];

    int win_cnt = 0;
    int comp_cnt = 0;
    int step_no = 0;
    int comp_step = -1;

    rb_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .out_ready (out_ready),
        .pix_take  (pix_take),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .col       (col),
        .wr_row    (wr_row),
        .steer     (steer),
        .win_valid (win_valid),
        .busy      (busy),
        .complete  (complete),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_col();
        return m_n % IMG_W;
    endfunction

    function automatic int m_slot();
        return (m_n / IMG_W) % (K - 1);
    endfunction

    function automatic logic m_adv(input logic pv, input logic ordy);
        return ((m_ph == ST_PRIME) && pv) || ((m_ph == ST_STREAM) && pv && ordy);
    endfunction

    task automatic model_reset();
        m_ph = ST_IDLE;
        m_n = 0;
        m_win = 1'b0;
        m_steer = '0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic pv, input logic ordy);
        logic adv;
        adv = m_adv(pv, ordy);
        m_win = (m_ph == ST_STREAM) && adv;
        m_steer = SW'(m_slot());
        if (m_win) exp_q.push_back(m_steer);
        case (m_ph)
            ST_IDLE:   if (s) begin m_ph = ST_PRIME; m_n = 0; end
            ST_PRIME:  if (adv) begin m_n++; if (m_n == PRIME_PIX) m_ph = ST_STREAM; end
            ST_STREAM: if (adv) begin m_n++; if (m_n == FRAME_PIX) m_ph = ST_DONE; end
            default:   m_ph = ST_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic adv;
        adv = m_adv(pix_valid, out_ready);
        chk("pix_take", pix_take, adv);
        chk("wr_en", wr_en, adv);
        chk("rd_en", rd_en, adv && (m_ph == ST_STREAM));
        chk("col", col, m_col());
        chk("wr_row", wr_row, m_slot());
        chk("steer", steer, m_steer);
        chk("win_valid", win_valid, m_win);
        chk("busy", busy, (m_ph == ST_PRIME) || (m_ph == ST_STREAM));
        chk("complete", complete, m_ph == ST_DONE);
        chk("state", state_dbg, m_ph);
        if (win_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("win_unexpected", exp_q.size(), 1);
            else chk("win_steer", steer, exp_q.pop_front());
            win_cnt++;
        end
        if (complete === 1'b1) begin
            comp_cnt++;
            comp_step = step_no;
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model on the edge.
    task automatic cycle(input logic s, input logic pv, input logic ordy);
        start = s;
        pix_valid = pv;
        out_ready = ordy;
        #2;
        check_all();
        @(posedge clk);
        model_edge(s, pv, ordy);
        #1;
        step_no++;
    endtask

    function automatic logic rbit();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_to_idle(input logic hold_start, input logic rnd);
        for (int i = 0; i < 2000 && m_ph != ST_IDLE; i++)
            cycle(hold_start, rnd ? rbit() : 1'b1, rnd ? rbit() : 1'b1);
        chk("frame_end_idle", state_dbg, ST_IDLE);
    endtask

    initial begin
        int w0, c0;
        model_reset();
        #3;
        chk("rst_col", col, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-throughput frame: timing and window count.
        step_no = 0;
        w0 = win_cnt;
        cycle(1'b1, 1'b1, 1'b1);
        run_to_idle(1'b0, 1'b0);
        chk("frame_win_count", win_cnt - w0, IMG_W * (IMG_H - K + 1));
        chk("frame_complete_step", comp_step, FRAME_PIX + 1);

        // out_ready stall mid-STREAM at column 3.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_ph == ST_STREAM && m_n == 5 * IMG_W + 3); i++)
            cycle(1'b0, 1'b1, 1'b1);
        w0 = win_cnt;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("stall_col", col, 3);
        chk("stall_no_win", win_cnt - w0, 1);
        run_to_idle(1'b0, 1'b0);

        // pix_valid drop during PRIME at column 3.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_ph == ST_PRIME && m_n == 3); i++)
            cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("prime_hold_col", col, 3);
        chk("prime_hold_state", state_dbg, ST_PRIME);
        run_to_idle(1'b0, 1'b0);

        // Asynchronous reset at STREAM column 5, then a fresh frame.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_ph == ST_STREAM && m_col() == 5); i++)
            cycle(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("areset_state", state_dbg, ST_IDLE);
        chk("areset_col", col, 0);
        chk("areset_wr_row", wr_row, 0);
        chk("areset_take", pix_take, 0);
        chk("areset_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b1);
        w0 = win_cnt;
        c0 = comp_cnt;
        cycle(1'b1, 1'b1, 1'b1);
        run_to_idle(1'b0, 1'b0);
        chk("replay_win_count", win_cnt - w0, IMG_W * (IMG_H - K + 1));
        chk("replay_complete", comp_cnt - c0, 1);

        // start held high through DONE: one complete, restart only via IDLE.
        c0 = comp_cnt;
        cycle(1'b1, 1'b1, 1'b1);
        run_to_idle(1'b1, 1'b0);
        chk("held_start_complete", comp_cnt - c0, 1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("held_start_restart", state_dbg, ST_PRIME);
        run_to_idle(1'b0, 1'b1);

        // Randomized frames with random idle gaps.
        for (int f = 0; f < 4; f++) begin
            c0 = comp_cnt;
            w0 = win_cnt;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) cycle(1'b0, rbit(), rbit());
            cycle(1'b1, rbit(), rbit());
            run_to_idle(1'b0, 1'b1);
            chk("rand_complete", comp_cnt - c0, 1);
            chk("rand_win_count", win_cnt - w0, IMG_W * (IMG_H - K + 1));
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
